// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Control bundles cover every stage enable/flush the controller drives.
package pipe_pkg;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_MD_WAIT  = 2'd1,
      S_MEM_WAIT = 2'd2
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_we;
      logic if_id_we;
      logic if_id_flush;
      logic id_ex_we;
      logic id_ex_sel;
      logic ex_mem_we;
      logic ex_mem_flush;
      logic mem_wb_flush;
      logic md_start;
   } ctrl_t;

   // Everything loads, nothing is squashed.
   localparam ctrl_t CTRL_RUN = '{
      pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0, id_ex_we: 1'b1, id_ex_sel: 1'b0,
      ex_mem_we: 1'b1, ex_mem_flush: 1'b0, mem_wb_flush: 1'b0, md_start: 1'b0
   };

   // While in reset the front end is frozen and every downstream stage takes a bubble.
   localparam ctrl_t CTRL_RST = '{
      pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b1, id_ex_we: 1'b1, id_ex_sel: 1'b1,
      ex_mem_we: 1'b1, ex_mem_flush: 1'b1, mem_wb_flush: 1'b1, md_start: 1'b0
   };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: the ID instruction reads the
// destination of a load currently in EX.
module load_use_detect
   import pipe_pkg::*;
(
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   output logic       hazard
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit = (ex_rt == id_rs);
      rt_hit = id_uses_rt && (ex_rt == id_rt);
      // $0 is hardwired, so a load targeting it never produces a dependency.
      hazard = ex_mem_read && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirect,
// fixed-latency mult/div and data-memory wait states.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned MD_LAT      = 32,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_MemRead,
   input  logic [4:0]       ex_rt,
   input  logic             ex_redirect,
   input  logic             ex_md_op,
   input  logic             mem_req,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             ID_EX_sel,
   output logic             ex_mem_we,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic             md_start,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   state_e           state_q, state_d;
   logic [7:0]       md_cnt_q, md_cnt_d;
   logic [7:0]       to_cnt_q, to_cnt_d;
   logic             ret_md_q, ret_md_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   state_e eff_state;
   logic   mem_wait;
   logic   lu_hazard;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;

   load_use_detect u_lu (
      .ex_mem_read (ex_MemRead),
      .ex_rt       (ex_rt),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .hazard      (lu_hazard)
   );

   always_comb begin
      ctrl        = CTRL_RUN;
      state_d     = state_q;
      md_cnt_d    = md_cnt_q;
      to_cnt_d    = to_cnt_q;
      ret_md_d    = ret_md_q;
      mem_err_d   = mem_err_q;
      stall_cnt_d = stall_cnt_q;

      mem_wait = mem_req && !dmem_ready;

      // A memory wait suspends whichever state it interrupted; resume from there.
      eff_state = state_q;
      if (state_q == S_MEM_WAIT) begin
         eff_state = ret_md_q ? S_MD_WAIT : S_RUN;
      end

      if (mem_wait) begin
         ctrl.pc_we        = 1'b0;
         ctrl.if_id_we     = 1'b0;
         ctrl.id_ex_we     = 1'b0;
         ctrl.ex_mem_we    = 1'b0;
         ctrl.mem_wb_flush = 1'b1;
         state_d           = S_MEM_WAIT;
         ret_md_d          = (eff_state == S_MD_WAIT);
         if (to_cnt_q != 8'hFF) begin
            to_cnt_d = to_cnt_q + 8'd1;
         end
         if ({24'd0, to_cnt_d} >= MEM_TIMEOUT) begin
            mem_err_d = 1'b1;
         end
      end else begin
         to_cnt_d = 8'd0;
         ret_md_d = 1'b0;
         case (eff_state)
            S_MD_WAIT: begin
               if (md_cnt_q == 8'd0) begin
                  state_d = S_RUN;
               end else begin
                  ctrl.pc_we        = 1'b0;
                  ctrl.if_id_we     = 1'b0;
                  ctrl.id_ex_we     = 1'b0;
                  ctrl.ex_mem_flush = 1'b1;
                  md_cnt_d          = md_cnt_q - 8'd1;
                  state_d           = S_MD_WAIT;
               end
            end
            default: begin
               state_d = S_RUN;
               if (ex_md_op) begin
                  ctrl.md_start     = 1'b1;
                  ctrl.pc_we        = 1'b0;
                  ctrl.if_id_we     = 1'b0;
                  ctrl.id_ex_we     = 1'b0;
                  ctrl.ex_mem_flush = 1'b1;
                  md_cnt_d          = 8'(MD_LAT - 2);
                  state_d           = S_MD_WAIT;
               end else if (ex_redirect) begin
                  ctrl.if_id_flush = 1'b1;
                  ctrl.id_ex_sel   = 1'b1;
               end else if (lu_hazard) begin
                  ctrl.pc_we     = 1'b0;
                  ctrl.if_id_we  = 1'b0;
                  ctrl.id_ex_sel = 1'b1;
               end
            end
         endcase
      end

      if (!ctrl.pc_we && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RUN;
         md_cnt_q    <= 8'd0;
         to_cnt_q    <= 8'd0;
         ret_md_q    <= 1'b0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         md_cnt_q    <= md_cnt_d;
         to_cnt_q    <= to_cnt_d;
         ret_md_q    <= ret_md_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Reset forces the bubble/hold pattern without waiting for a clock edge.
   always_comb begin
      ctrl_out = rst_n ? ctrl : CTRL_RST;
   end

   assign pc_we        = ctrl_out.pc_we;
   assign if_id_we     = ctrl_out.if_id_we;
   assign if_id_flush  = ctrl_out.if_id_flush;
   assign id_ex_we     = ctrl_out.id_ex_we;
   assign ID_EX_sel    = ctrl_out.id_ex_sel;
   assign ex_mem_we    = ctrl_out.ex_mem_we;
   assign ex_mem_flush = ctrl_out.ex_mem_flush;
   assign mem_wb_flush = ctrl_out.mem_wb_flush;
   assign md_start     = ctrl_out.md_start;
   assign mem_err      = mem_err_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs are queued per step
// and checked against the DUT between clock edges.
module tb_pipe_hazard_ctrl;

   localparam int unsigned CNT_W = 16;

   // {pc_we, if_id_we, if_id_flush, id_ex_we, ID_EX_sel, ex_mem_we, ex_mem_flush, mem_wb_flush, md_start}
   localparam logic [8:0] O_RUN = 9'b1_1_0_1_0_1_0_0_0;
   localparam logic [8:0] O_RST = 9'b0_0_1_1_1_1_1_1_0;
   localparam logic [8:0] O_LU  = 9'b0_0_0_1_1_1_0_0_0;
   localparam logic [8:0] O_RD  = 9'b1_1_1_1_1_1_0_0_0;
   localparam logic [8:0] O_MDI = 9'b0_0_0_0_0_1_1_0_1;
   localparam logic [8:0] O_MDW = 9'b0_0_0_0_0_1_1_0_0;
   localparam logic [8:0] O_MW  = 9'b0_0_0_0_0_0_0_1_0;

   typedef struct {
      string            tag;
      logic [8:0]       outs;
      logic [CNT_W-1:0] stall;
      logic             err;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [4:0]       id_rs = '0, id_rt = '0, ex_rt = '0;
   logic             id_uses_rt = 1'b0, ex_MemRead = 1'b0, ex_redirect = 1'b0;
   logic             ex_md_op = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
   logic             pc_we, if_id_we, if_id_flush, id_ex_we, ID_EX_sel;
   logic             ex_mem_we, ex_mem_flush, mem_wb_flush, md_start, mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [8:0]       obs;

   exp_t             sb[$];
   int               total = 0;
   int               bad = 0;
   logic [CNT_W-1:0] exp_stall = '0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(4), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .ex_MemRead   (ex_MemRead),
      .ex_rt        (ex_rt),
      .ex_redirect  (ex_redirect),
      .ex_md_op     (ex_md_op),
      .mem_req      (mem_req),
      .dmem_ready   (dmem_ready),
      .pc_we        (pc_we),
      .if_id_we     (if_id_we),
      .if_id_flush  (if_id_flush),
      .id_ex_we     (id_ex_we),
      .ID_EX_sel    (ID_EX_sel),
      .ex_mem_we    (ex_mem_we),
      .ex_mem_flush (ex_mem_flush),
      .mem_wb_flush (mem_wb_flush),
      .md_start     (md_start),
      .mem_err      (mem_err),
      .stall_cnt    (stall_cnt)
   );

   assign obs = {pc_we, if_id_we, if_id_flush, id_ex_we, ID_EX_sel,
                 ex_mem_we, ex_mem_flush, mem_wb_flush, md_start};

   // Called just after a falling edge: drive, queue expectation, sample before the rising edge.
   task automatic step(input string tag, input logic rst_v,
                       input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic redir,
                       input logic md, input logic mreq, input logic rdy,
                       input logic [8:0] outs, input logic err_v);
      exp_t e;
      rst_n       = rst_v;
      ex_MemRead  = mr;
      ex_rt       = xrt;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rt  = urt;
      ex_redirect = redir;
      ex_md_op    = md;
      mem_req     = mreq;
      dmem_ready  = rdy;
      if (!rst_v) exp_stall = '0;
      sb.push_back('{tag: tag, outs: outs, stall: exp_stall, err: err_v});
      #2;
      e = sb.pop_front();
      total++;
      assert (obs === e.outs) else begin
         bad++;
         $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.outs);
      end
      total++;
      assert (stall_cnt === e.stall) else begin
         bad++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", e.tag, stall_cnt, e.stall);
      end
      total++;
      assert (mem_err === e.err) else begin
         bad++;
         $error("FAIL %s mem_err observed=%b expected=%b", e.tag, mem_err, e.err);
      end
      if (rst_v && !outs[8]) exp_stall = exp_stall + CNT_W'(1);
      @(negedge clk);
   endtask

   initial begin
      //    tag          rst mr xrt rs  rt  urt rd md mq rdy outs   err
      step("reset",      0, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RST, 0);
      step("idle",       1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      step("lu_rs",      1, 1, 8,  8,  0,  0,  0, 0, 0, 0, O_LU,  0);
      step("lu_after",   1, 0, 0,  8,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      step("lu_rt",      1, 1, 9,  3,  9,  1,  0, 0, 0, 0, O_LU,  0);
      step("rt_unused",  1, 1, 9,  3,  9,  0,  0, 0, 0, 0, O_RUN, 0);
      step("lu_r0",      1, 1, 0,  0,  0,  1,  0, 0, 0, 0, O_RUN, 0);
      step("redir_lu",   1, 1, 8,  8,  0,  0,  1, 0, 0, 0, O_RD,  0);
      step("redir_post", 1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      // Mult/div with MD_LAT=4: issue plus two holds, fourth cycle normal.
      step("md_issue",   1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDI, 0);
      step("md_wait1",   1, 0, 0,  0,  0,  0,  1, 1, 0, 0, O_MDW, 0);
      step("md_wait2",   1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDW, 0);
      step("md_done",    1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_RUN, 0);
      step("md_post",    1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      // Memory wait injected while the mult/div is pending.
      step("mdm_issue",  1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDI, 0);
      step("mdm_wait1",  1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDW, 0);
      step("mdm_mw1",    1, 0, 0,  0,  0,  0,  0, 1, 1, 0, O_MW,  0);
      step("mdm_mw2",    1, 0, 0,  0,  0,  0,  0, 1, 1, 0, O_MW,  0);
      step("mdm_resume", 1, 0, 0,  0,  0,  0,  0, 1, 1, 1, O_MDW, 0);
      step("mdm_done",   1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_RUN, 0);
      step("mdm_post",   1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      // Timeout with MEM_TIMEOUT=4.
      step("to_1",       1, 0, 0,  0,  0,  0,  0, 0, 1, 0, O_MW,  0);
      step("to_2",       1, 0, 0,  0,  0,  0,  0, 0, 1, 0, O_MW,  0);
      step("to_3",       1, 0, 0,  0,  0,  0,  0, 0, 1, 0, O_MW,  0);
      step("to_4",       1, 0, 0,  0,  0,  0,  0, 0, 1, 0, O_MW,  0);
      step("to_5",       1, 0, 0,  0,  0,  0,  0, 0, 1, 0, O_MW,  1);
      step("to_ready",   1, 0, 0,  0,  0,  0,  0, 0, 1, 1, O_RUN, 1);
      step("to_sticky",  1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 1);
      // Asynchronous reset in the middle of a mult/div wait.
      step("ar_issue",   1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDI, 1);
      step("ar_wait",    1, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_MDW, 1);
      step("ar_reset",   0, 0, 0,  0,  0,  0,  0, 1, 0, 0, O_RST, 0);
      step("ar_run",     1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      step("ar_run2",    1, 1, 8,  8,  0,  0,  0, 0, 0, 0, O_LU,  0);
      step("ar_run3",    1, 0, 0,  0,  0,  0,  0, 0, 0, 0, O_RUN, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Decides each cycle which pipeline registers load, hold or take a bubble. It drives the ID/EX `ID_EX_sel` bubble input and the per-stage write enables.
- Resolves four hazards: load-use, EX-stage branch/jump redirect, fixed-latency multi-cycle mult/div, and data-memory wait states.
- Outputs are combinational from state and inputs. The FSM, latency counter, timeout counter and performance counter are registered.

Parameters:
- MD_LAT, 32: total EX-stage cycles of a mult/div op, including the issue cycle; legal range 2..255.
- MEM_TIMEOUT, 64: consecutive dmem wait cycles before `mem_err` sets; must be at least 1.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- id_rs, in, 5: rs field of the instruction in ID.
- id_rt, in, 5: rt field of the instruction in ID.
- id_uses_rt, in, 1: the ID instruction reads rt as a source.
- ex_MemRead, in, 1: the EX instruction is a load.
- ex_rt, in, 5: destination (rt) of the EX load.
- ex_redirect, in, 1: taken branch or jump resolved in EX.
- ex_md_op, in, 1: the EX instruction is a mult/div.
- mem_req, in, 1: the MEM instruction accesses data memory (read or write).
- dmem_ready, in, 1: data memory completes the access this cycle.
- pc_we, out, 1: PC loads.
- if_id_we, out, 1: IF/ID loads.
- if_id_flush, out, 1: IF/ID loads a NOP.
- id_ex_we, out, 1: ID/EX loads (new enable on ID/EX).
- ID_EX_sel, out, 1: ID/EX control fields load zero (bubble).
- ex_mem_we, out, 1: EX/MEM loads.
- ex_mem_flush, out, 1: EX/MEM loads a bubble.
- mem_wb_flush, out, 1: MEM/WB loads a bubble.
- md_start, out, 1: one-cycle start pulse to the mult/div unit.
- mem_err, out, 1: sticky memory-timeout flag.
- stall_cnt, out, CNT_W: saturating count of cycles with `pc_we` = 0.

Behaviour:
- **States:** S_RUN, S_MD_WAIT, S_MEM_WAIT. Counters `md_cnt` (8 bits) and `to_cnt` (8 bits).
- **Reset (rst_n = 0, asynchronous):**
  - State = S_RUN; `md_cnt`, `to_cnt`, `stall_cnt` and `mem_err` = 0.
  - Outputs: `pc_we` = 0, `if_id_we` = 0, `if_id_flush` = 1, `id_ex_we` = 1, `ID_EX_sel` = 1, `ex_mem_we` = 1, `ex_mem_flush` = 1, `mem_wb_flush` = 1, `md_start` = 0.
  - Reset asserted mid-operation aborts any wait.
- **Default (S_RUN, no hazard):**
  - All `*_we` = 1.
  - All flushes = 0, `ID_EX_sel` = 0, `md_start` = 0.
- **Priority, highest first:** MEM wait, MD wait/issue, redirect, load-use.
- **MEM wait** (`mem_req` & !`dmem_ready`, in any state):
  - Outputs: `pc_we` = `if_id_we` = `id_ex_we` = `ex_mem_we` = 0, `mem_wb_flush` = 1.
  - Transition: next state S_MEM_WAIT; `to_cnt` increments.
  - Timeout: `to_cnt` reaching MEM_TIMEOUT sets `mem_err`, which clears only on reset.
  - Exit: when `dmem_ready` = 1, a normal cycle executes; state returns to S_RUN, or to S_MD_WAIT if it was entered from there; `to_cnt` = 0.
  - In S_MD_WAIT, `md_cnt` freezes while the MEM wait is active.
- **MD issue** (S_RUN, `ex_md_op` = 1, no MEM wait):
  - Outputs: `md_start` = 1; `pc_we` = `if_id_we` = `id_ex_we` = 0; `ex_mem_flush` = 1.
  - Transition: next state S_MD_WAIT, `md_cnt` = MD_LAT-2.
- **S_MD_WAIT:**
  - Same hold/flush outputs as MD issue, with `md_start` = 0.
  - `md_cnt` decrements each cycle.
  - When `md_cnt` = 0, that cycle is a normal RUN cycle: the op advances to MEM and the next state is S_RUN.
  - Total EX residency is exactly MD_LAT cycles.
- **Redirect** (`ex_redirect`):
  - Outputs: `pc_we` = 1, `if_id_flush` = 1, `ID_EX_sel` = 1, others default.
  - Redirect wins over a simultaneous load-use.
- **Load-use:**
  - Condition: `ex_MemRead` & `ex_rt` != 0 & (`ex_rt` == `id_rs` | (`id_uses_rt` & `ex_rt` == `id_rt`)).
  - Outputs: `pc_we` = 0, `if_id_we` = 0, `ID_EX_sel` = 1, others default.
  - Exactly one bubble cycle.
  - Register $0 never causes a stall.
- **stall_cnt:** +1 on every post-reset cycle with `pc_we` = 0; saturates at all-ones and does not wrap.

Decomposition:
- Shared package `pipe_pkg`:
  - State encoding: S_RUN = 2'd0, S_MD_WAIT = 2'd1, S_MEM_WAIT = 2'd2.
  - Constant REG_ZERO = 5'd0.
- One sub-module, `load_use_detect`: purely combinational comparator for the load-use condition.
- FSM and counters stay in `pipe_hazard_ctrl`.

Test Plan:
- **Load-use:** `ex_MemRead` = 1, `ex_rt` = 8, `id_rs` = 8 → one cycle with `pc_we` = 0, `if_id_we` = 0, `ID_EX_sel` = 1. Repeat with `ex_rt` = 0 → no stall.
- **Redirect vs load-use:** `ex_redirect` = 1 together with a load-use match → `if_id_flush` = 1, `ID_EX_sel` = 1, `pc_we` = 1; `stall_cnt` unchanged.
- **MD latency:** MD_LAT = 4, pulse `ex_md_op` → `md_start` high one cycle; `pc_we` = 0 for exactly 3 cycles, `ex_mem_flush` = 1 for 3 cycles; 4th cycle normal; `stall_cnt` = 3.
- **Wait during MD:** `mem_req` = 1 with `dmem_ready` = 0 for 2 cycles during S_MD_WAIT → full freeze and `md_cnt` held; total `pc_we` = 0 count = MD_LAT-1+2.
- **Timeout:** MEM_TIMEOUT = 4, `dmem_ready` held 0 for 5 cycles → `mem_err` = 1 and remains 1 after `dmem_ready`; reset clears it.
- **Async reset mid-MD:** drop `rst_n` mid-S_MD_WAIT, no clock edge → all outputs take reset values immediately; after release, S_RUN and `stall_cnt` = 0.
